// File: rtl/phase_clock_gen.sv
// Multi-phase clock-enable generator: NUM_PHASES evenly spaced one-cycle strobes per frame,
// with frame-aligned stall/acknowledge (STALL_MODE=0) or immediate output masking (STALL_MODE=1).
module phase_clock_gen #(
  parameter int unsigned NUM_PHASES  = 2,
  parameter int unsigned SP_W        = 4,
  parameter int unsigned DEF_SPACING = 2,
  parameter int unsigned STALL_MODE  = 0
) (
  input  logic                  clk_i,
  input  logic                  clear_i,
  input  logic [SP_W-1:0]       spacing_i,
  input  logic                  cfg_we_i,
  input  logic                  stall_i,
  output logic                  clk_o,
  output logic                  clear_o,
  output logic [NUM_PHASES-1:0] phi_o,
  output logic                  frame_o,
  output logic                  stall_ack_o
);

  localparam int unsigned PW = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [SP_W-1:0]       s_q, s_d;
  logic [PW-1:0]         p_q, p_d;
  logic [SP_W-1:0]       act_sp_q, act_sp_d;
  logic [SP_W-1:0]       pend_sp_q, pend_sp_d;
  logic                  pend_v_q, pend_v_d;
  logic [NUM_PHASES-1:0] phi_q, phi_d;
  logic                  frame_q, frame_d;
  logic                  ack_q, ack_d;

  logic [SP_W-1:0]       eff_sp;
  logic                  counting;
  logic                  s_last;
  logic                  p_last;
  logic                  wrap;

  assign clk_o   = clk_i;
  assign clear_o = clear_i;

  always_comb begin
    eff_sp   = (act_sp_q == '0) ? SP_W'(1) : act_sp_q;
    counting = (state_q != ST_HALT);
    s_last   = (s_q == eff_sp - SP_W'(1));
    p_last   = (p_q == PW'(NUM_PHASES - 1));
    wrap     = counting && s_last && p_last;
  end

  // Halt is only entered on a wrap edge so a started frame always completes.
  always_comb begin
    state_d = state_q;
    if (STALL_MODE == 0) begin
      case (state_q)
        ST_RUN: begin
          if (stall_i) state_d = wrap ? ST_HALT : ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!stall_i)  state_d = ST_RUN;
          else if (wrap) state_d = ST_HALT;
        end
        ST_HALT: begin
          if (!stall_i) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end else begin
      state_d = ST_RUN;
    end
    ack_d = (state_d == ST_HALT);
  end

  always_comb begin
    s_d = s_q;
    p_d = p_q;
    if (counting) begin
      if (s_last) begin
        s_d = '0;
        p_d = p_last ? '0 : p_q + PW'(1);
      end else begin
        s_d = s_q + SP_W'(1);
      end
    end else begin
      s_d = '0;
      p_d = '0;
    end
  end

  always_comb begin
    phi_d = '0;
    if (counting && (s_q == '0)) begin
      for (int unsigned i = 0; i < NUM_PHASES; i++) begin
        phi_d[i] = (p_q == PW'(i));
      end
    end
    frame_d = phi_d[0];
  end

  // A write coinciding with a wrap only lands in pending; act_sp takes the older pending value.
  always_comb begin
    pend_sp_d = cfg_we_i ? spacing_i : pend_sp_q;
    act_sp_d  = act_sp_q;
    pend_v_d  = pend_v_q;
    if ((wrap || (state_q == ST_HALT)) && pend_v_q) begin
      act_sp_d = pend_sp_q;
      pend_v_d = 1'b0;
    end
    if (cfg_we_i) pend_v_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge clear_i) begin
    if (!clear_i) begin
      state_q   <= ST_RUN;
      s_q       <= '0;
      p_q       <= '0;
      act_sp_q  <= SP_W'(DEF_SPACING);
      pend_sp_q <= '0;
      pend_v_q  <= 1'b0;
      phi_q     <= '0;
      frame_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      p_q       <= p_d;
      act_sp_q  <= act_sp_d;
      pend_sp_q <= pend_sp_d;
      pend_v_q  <= pend_v_d;
      phi_q     <= phi_d;
      frame_q   <= frame_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    if (STALL_MODE == 1) begin
      phi_o       = phi_q & ~{NUM_PHASES{stall_i}};
      frame_o     = frame_q & ~stall_i;
      stall_ack_o = stall_i;
    end else begin
      phi_o       = phi_q;
      frame_o     = frame_q;
      stall_ack_o = ack_q;
    end
  end

endmodule

// File: tb/tb_phase_clock_gen.sv
// Directed bench for phase_clock_gen: one graceful-stall instance and one immediate-mask instance.
module tb_phase_clock_gen;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic [3:0] spacing = '0;
  logic       cfg_we = 1'b0;
  logic       stall = 1'b0;
  logic       stall_m1 = 1'b0;

  logic       clk_o0, clear_o0, frame0, ack0;
  logic [1:0] phi0;
  logic       clk_o1, clear_o1, frame1, ack1;
  logic [1:0] phi1;

  int n_checks = 0;
  int n_errors = 0;

  phase_clock_gen #(.NUM_PHASES(2), .SP_W(4), .DEF_SPACING(2), .STALL_MODE(0)) u_dut (
    .clk_i(clk), .clear_i(clear_n), .spacing_i(spacing), .cfg_we_i(cfg_we), .stall_i(stall),
    .clk_o(clk_o0), .clear_o(clear_o0), .phi_o(phi0), .frame_o(frame0), .stall_ack_o(ack0)
  );

  phase_clock_gen #(.NUM_PHASES(2), .SP_W(4), .DEF_SPACING(2), .STALL_MODE(1)) u_dut_m1 (
    .clk_i(clk), .clear_i(clear_n), .spacing_i(spacing), .cfg_we_i(cfg_we), .stall_i(stall_m1),
    .clk_o(clk_o1), .clear_o(clear_o1), .phi_o(phi1), .frame_o(frame1), .stall_ack_o(ack1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Default frame: spacing 2, strobes phi[0] at edges 1,5,9 and phi[1] at 3,7,11.
  function automatic logic [1:0] exp_basic(input int e);
    if (e % 4 == 1)      return 2'b01;
    else if (e % 4 == 3) return 2'b10;
    else                 return 2'b00;
  endfunction

  task automatic apply_reset();
    clear_n  = 1'b0;
    cfg_we   = 1'b0;
    spacing  = '0;
    stall    = 1'b0;
    stall_m1 = 1'b0;
    tick();
    tick();
    clear_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (phi0 !== 2'b00 || frame0 !== 1'b0 || ack0 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_m0: phi=%b frame=%b ack=%b expected 00 0 0", phi0, frame0, ack0);
    end
    n_checks++;
    if (phi1 !== 2'b00 || frame1 !== 1'b0 || ack1 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_m1: phi=%b frame=%b ack=%b expected 00 0 0", phi1, frame1, ack1);
    end
    n_checks++;
    if (clear_o0 !== 1'b0 || clear_o1 !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_pass_low: clear_o=%b/%b expected 0", clear_o0, clear_o1);
    end
    clear_n = 1'b1;
    #1;
    n_checks++;
    if (clear_o0 !== 1'b1 || clk_o0 !== clk || clk_o1 !== clk) begin
      n_errors++;
      $display("FAIL passthrough: clear_o=%b clk_o=%b expected 1 %b", clear_o0, clk_o0, clk);
    end
    n_checks++;
    if (phi0 !== 2'b00 || frame0 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: phi=%b frame=%b expected 00 0", phi0, frame0);
    end
  endtask

  task automatic test_basic();
    logic [1:0] ex;
    apply_reset();
    for (int e = 1; e <= 12; e++) begin
      tick();
      ex = exp_basic(e);
      n_checks++;
      if (phi0 !== ex || frame0 !== ex[0] || ack0 !== 1'b0) begin
        n_errors++;
        $display("FAIL basic_m0 e=%0d: phi=%b frame=%b ack=%b expected %b %b 0", e, phi0, frame0, ack0, ex, ex[0]);
      end
      n_checks++;
      if (phi1 !== ex || frame1 !== ex[0] || ack1 !== 1'b0) begin
        n_errors++;
        $display("FAIL basic_m1 e=%0d: phi=%b frame=%b ack=%b expected %b %b 0", e, phi1, frame1, ack1, ex, ex[0]);
      end
    end
  endtask

  task automatic test_spacing_update();
    logic [1:0] ex;
    apply_reset();
    for (int e = 1; e <= 12; e++) begin
      tick();
      case (e)
        1, 5, 11: ex = 2'b01;
        3, 8:     ex = 2'b10;
        default:  ex = 2'b00;
      endcase
      n_checks++;
      if (phi0 !== ex || frame0 !== ex[0]) begin
        n_errors++;
        $display("FAIL spacing_m0 e=%0d: phi=%b frame=%b expected %b %b", e, phi0, frame0, ex, ex[0]);
      end
      n_checks++;
      if (phi1 !== ex || frame1 !== ex[0]) begin
        n_errors++;
        $display("FAIL spacing_m1 e=%0d: phi=%b frame=%b expected %b %b", e, phi1, frame1, ex, ex[0]);
      end
      if (e == 1) begin
        cfg_we  = 1'b1;
        spacing = 4'd3;
      end
      if (e == 2) cfg_we = 1'b0;
    end
  endtask

  task automatic test_stall_halt();
    logic [1:0] ex;
    logic       ex_ack;
    apply_reset();
    for (int e = 1; e <= 15; e++) begin
      tick();
      case (e)
        1, 5, 13: ex = 2'b01;
        3, 7, 15: ex = 2'b10;
        default:  ex = 2'b00;
      endcase
      ex_ack = (e >= 8 && e <= 11);
      n_checks++;
      if (phi0 !== ex || frame0 !== ex[0] || ack0 !== ex_ack) begin
        n_errors++;
        $display("FAIL stall_halt e=%0d: phi=%b frame=%b ack=%b expected %b %b %b",
                 e, phi0, frame0, ack0, ex, ex[0], ex_ack);
      end
      if (e == 5)  stall = 1'b1;
      if (e == 11) stall = 1'b0;
    end
  endtask

  task automatic test_stall_pulse();
    logic [1:0] ex;
    apply_reset();
    for (int e = 1; e <= 12; e++) begin
      tick();
      ex = exp_basic(e);
      n_checks++;
      if (phi0 !== ex || frame0 !== ex[0] || ack0 !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_pulse e=%0d: phi=%b frame=%b ack=%b expected %b %b 0", e, phi0, frame0, ack0, ex, ex[0]);
      end
      if (e == 2) stall = 1'b1;
      if (e == 3) stall = 1'b0;
    end
  endtask

  task automatic test_zero_spacing();
    logic [1:0] ex;
    logic       ex_ack;
    apply_reset();
    stall = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick();
      case (e)
        1, 8, 10: ex = 2'b01;
        3, 9, 11: ex = 2'b10;
        default:  ex = 2'b00;
      endcase
      ex_ack = (e >= 4 && e <= 6);
      n_checks++;
      if (phi0 !== ex || frame0 !== ex[0] || ack0 !== ex_ack) begin
        n_errors++;
        $display("FAIL zero_spacing e=%0d: phi=%b frame=%b ack=%b expected %b %b %b",
                 e, phi0, frame0, ack0, ex, ex[0], ex_ack);
      end
      if (e == 4) begin
        cfg_we  = 1'b1;
        spacing = 4'd0;
      end
      if (e == 5) cfg_we = 1'b0;
      if (e == 6) stall  = 1'b0;
    end
  endtask

  task automatic test_async_clear();
    logic [1:0] ex;
    apply_reset();
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e == 3) begin
        cfg_we  = 1'b1;
        spacing = 4'd5;
      end
      if (e == 4) cfg_we = 1'b0;
    end
    n_checks++;
    if (phi0 !== 2'b01 || frame0 !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_clear: phi=%b frame=%b expected 01 1", phi0, frame0);
    end
    #2;
    clear_n = 1'b0;
    #1;
    n_checks++;
    if (phi0 !== 2'b00 || frame0 !== 1'b0 || ack0 !== 1'b0) begin
      n_errors++;
      $display("FAIL async_clear_m0: phi=%b frame=%b ack=%b expected 00 0 0", phi0, frame0, ack0);
    end
    n_checks++;
    if (phi1 !== 2'b00 || frame1 !== 1'b0 || ack1 !== 1'b0) begin
      n_errors++;
      $display("FAIL async_clear_m1: phi=%b frame=%b ack=%b expected 00 0 0", phi1, frame1, ack1);
    end
    tick();
    clear_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      ex = exp_basic(e);
      n_checks++;
      if (phi0 !== ex || frame0 !== ex[0]) begin
        n_errors++;
        $display("FAIL restart e=%0d: phi=%b frame=%b expected %b %b", e, phi0, frame0, ex, ex[0]);
      end
    end
  endtask

  task automatic test_mode1_mask();
    apply_reset();
    tick();
    n_checks++;
    if (phi1 !== 2'b01 || frame1 !== 1'b1 || ack1 !== 1'b0) begin
      n_errors++;
      $display("FAIL m1_edge1: phi=%b frame=%b ack=%b expected 01 1 0", phi1, frame1, ack1);
    end
    stall_m1 = 1'b1;
    #1;
    n_checks++;
    if (phi1 !== 2'b00 || frame1 !== 1'b0 || ack1 !== 1'b1) begin
      n_errors++;
      $display("FAIL m1_mask: phi=%b frame=%b ack=%b expected 00 0 1", phi1, frame1, ack1);
    end
    n_checks++;
    if (phi0 !== 2'b01 || ack0 !== 1'b0) begin
      n_errors++;
      $display("FAIL m0_isolated: phi=%b ack=%b expected 01 0", phi0, ack0);
    end
    tick();
    tick();
    n_checks++;
    if (phi1 !== 2'b00 || ack1 !== 1'b1) begin
      n_errors++;
      $display("FAIL m1_masked_e3: phi=%b ack=%b expected 00 1", phi1, ack1);
    end
    stall_m1 = 1'b0;
    #1;
    n_checks++;
    if (phi1 !== 2'b10 || frame1 !== 1'b0 || ack1 !== 1'b0) begin
      n_errors++;
      $display("FAIL m1_unmask: phi=%b frame=%b ack=%b expected 10 0 0", phi1, frame1, ack1);
    end
    tick();
    tick();
    n_checks++;
    if (phi1 !== 2'b01 || frame1 !== 1'b1) begin
      n_errors++;
      $display("FAIL m1_continue: phi=%b frame=%b expected 01 1", phi1, frame1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_spacing_update();
    test_stall_halt();
    test_stall_pulse();
    test_zero_spacing();
    test_async_clear();
    test_mode1_mask();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
